// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and width constants shared by extmem_ctrl and wbuf
package mem_pkg;
  typedef enum logic [1:0] {IDLE, IRD, DRD, WR} state_t;
  localparam int ADR_W_DEF = 13;
  localparam int BE_W = 4;
endpackage

// File: rtl/wbuf.sv
// wbuf: posted-write FIFO (address, data, byte enables) with per-entry address match for read hazards
module wbuf import mem_pkg::*; #(
  parameter int AW = ADR_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [AW-1:0]   wadr,
  input  logic [31:0]     wdat,
  input  logic [BE_W-1:0] wbe,
  output logic [AW-1:0]   hadr,
  output logic [31:0]     hdat,
  output logic [BE_W-1:0] hbe,
  output logic            full,
  output logic            empty,
  input  logic [AW-1:0]   qadr0,
  input  logic [AW-1:0]   qadr1,
  output logic            hit0,
  output logic            hit1
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] adr_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [BE_W-1:0] be_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] rd, wr;
  assign full = &vld;
  assign empty = ~|vld;
  assign hadr = adr_q[rd];
  assign hdat = dat_q[rd];
  assign hbe = be_q[rd];
  always_ff @(posedge ph1) begin
    if (reset) begin
      vld <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      if (pop) begin
        vld[rd] <= 1'b0;
        rd <= rd + PW'(1);
      end
      // on a full FIFO wr==rd, so a same-cycle push refills the slot being popped
      if (push) begin
        vld[wr] <= 1'b1;
        wr <= wr + PW'(1);
      end
    end
  end
  always_ff @(posedge ph1) begin
    if (push) begin
      adr_q[wr] <= wadr;
      dat_q[wr] <= wdat;
      be_q[wr] <= wbe;
    end
  end
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0 = hit0 | (vld[i] && adr_q[i] == qadr0);
      hit1 = hit1 | (vld[i] && adr_q[i] == qadr1);
    end
  end
endmodule

// File: rtl/extmem_ctrl.sv
// extmem_ctrl: arbitrates instruction fetches and data accesses onto one external memory port.
// Define EXTMEM_CTRL_WBUF_EN to post data writes through a WBUF_DEPTH-entry write buffer.
module extmem_ctrl import mem_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter int WBUF_DEPTH = 2
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             ireq,
  input  logic [ADR_W-1:0] iadr,
  output logic [31:0]      irdata,
  output logic             idone,
  input  logic             dreq,
  input  logic             drwb,
  input  logic [ADR_W-1:0] dadr,
  input  logic [31:0]      dwdata,
  input  logic [BE_W-1:0]  dbyteen,
  output logic [31:0]      drdata,
  output logic             ddone,
  output logic [ADR_W-1:0] madr,
  inout  wire  [31:0]      mdata,
  output logic [BE_W-1:0]  mbyteen,
  output logic             mrwb,
  output logic             men,
  input  logic             mdone
);
  state_t state, nxt;
  logic [31:0] wdat, g_dat;
  logic [ADR_W-1:0] g_adr;
  logic [BE_W-1:0] g_be;
  logic g_rwb, grant, dread, dwrite, busy_done, dpost;
  assign men = state != IDLE;
  assign mdata = (men && !mrwb) ? wdat : 'z;
  assign dread = dreq && drwb;
  assign dwrite = dreq && !drwb;
  // a done pulse means its requester has not yet dropped the request; do not re-arbitrate on it
  assign busy_done = idone || ddone;
  assign grant = state == IDLE && nxt != IDLE;
`ifdef EXTMEM_CTRL_WBUF_EN
  logic push, pop, full, empty, dhit, ihit;
  logic [ADR_W-1:0] hadr;
  logic [31:0] hdat;
  logic [BE_W-1:0] hbe;
  assign pop = state == WR && mdone;
  assign push = dwrite && !ddone && (!full || pop);
  assign dpost = push;
  wbuf #(.AW(ADR_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .ph1(ph1), .reset(reset), .push(push), .pop(pop),
    .wadr(dadr), .wdat(dwdata), .wbe(dbyteen),
    .hadr(hadr), .hdat(hdat), .hbe(hbe), .full(full), .empty(empty),
    .qadr0(dadr), .qadr1(iadr), .hit0(dhit), .hit1(ihit)
  );
  always_comb begin
    nxt = (state != IDLE && mdone) ? IDLE : state;
    g_adr = (nxt == IRD) ? iadr : dadr;
    g_rwb = 1'b1;
    g_be = '1;
    g_dat = hdat;
    if (state == IDLE && !busy_done) begin
      if (full) nxt = WR;
      else if (dread && !dhit) nxt = DRD;
      else if (ireq && !ihit) nxt = IRD;
      else if (!empty) nxt = WR;
    end
    if (nxt == IRD) g_adr = iadr;
    if (nxt == WR) begin
      g_adr = hadr;
      g_rwb = 1'b0;
      g_be = hbe;
    end
  end
`else
  assign dpost = state == WR && mdone;
  always_comb begin
    nxt = (state != IDLE && mdone) ? IDLE : state;
    g_adr = dadr;
    g_rwb = 1'b1;
    g_be = '1;
    g_dat = dwdata;
    if (state == IDLE && !busy_done) begin
      if (dread) nxt = DRD;
      else if (ireq) nxt = IRD;
      else if (dwrite) nxt = WR;
    end
    if (nxt == IRD) g_adr = iadr;
    if (nxt == WR) begin
      g_rwb = 1'b0;
      g_be = dbyteen;
    end
  end
`endif
  always_ff @(posedge ph1) begin
    if (reset) begin
      state <= IDLE;
      madr <= '0;
      mrwb <= 1'b1;
      mbyteen <= '0;
      wdat <= '0;
      idone <= 1'b0;
      ddone <= 1'b0;
      irdata <= '0;
      drdata <= '0;
    end else begin
      state <= nxt;
      idone <= state == IRD && mdone;
      ddone <= (state == DRD && mdone) || dpost;
      if (state == IRD && mdone) irdata <= mdata;
      if (state == DRD && mdone) drdata <= mdata;
      if (grant) begin
        madr <= g_adr;
        mrwb <= g_rwb;
        mbyteen <= g_be;
        wdat <= g_dat;
      end else if (men && mdone) begin
        mrwb <= 1'b1;
        mbyteen <= '0;
      end
    end
  end
endmodule

// File: tb/tb_extmem_ctrl.sv
// tb_extmem_ctrl: directed self-checking bench for extmem_ctrl with a byte-lane external memory model
module tb_extmem_ctrl;
  localparam int AW = 13;
  logic ph1 = 1'b0, reset = 1'b1, ireq = 1'b0, dreq = 1'b0, drwb = 1'b1, mdone = 1'b1;
  logic [AW-1:0] iadr = '0, dadr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0] dbyteen = '0;
  logic [31:0] irdata, drdata;
  logic idone, ddone, mrwb, men;
  logic [AW-1:0] madr;
  logic [3:0] mbyteen;
  wire [31:0] mdata;
  logic [31:0] mem [256];
  int pass_n = 0, total_n = 0;

  extmem_ctrl #(.ADR_W(AW), .WBUF_DEPTH(2)) dut (
    .ph1(ph1), .reset(reset), .ireq(ireq), .iadr(iadr), .irdata(irdata), .idone(idone),
    .dreq(dreq), .drwb(drwb), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata), .ddone(ddone), .madr(madr), .mdata(mdata), .mbyteen(mbyteen),
    .mrwb(mrwb), .men(men), .mdone(mdone)
  );

  always #5 ph1 = ~ph1;

  function automatic logic [31:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    case (a)
      'h10: pat = 32'h8C020004;
      'h20: pat = 32'h11223344;
      'h21: pat = 32'h55AA00FF;
      'h40: pat = 32'hCAFE0000;
      'h60: pat = 32'hAAAAAAAA;
      default: pat = {8'hA5, b, 8'h5A, b};
    endcase
  endfunction

  assign mdata = (men && mrwb) ? mem[madr[7:0]] : 'z;

  always @(posedge ph1) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= pat(a);
    end else if (men && !mrwb && mdone) begin
      for (int b = 0; b < 4; b++)
        if (mbyteen[b]) mem[madr[7:0]][8*b +: 8] <= mdata[8*b +: 8];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ph1);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick;
    total_n++; if (men !== 1'b0) $display("FAIL reset_men: got %b want 0", men); else pass_n++;
    total_n++; if (mrwb !== 1'b1) $display("FAIL reset_mrwb: got %b want 1", mrwb); else pass_n++;
    total_n++; if (mbyteen !== 4'b0) $display("FAIL reset_mbyteen: got %b want 0000", mbyteen); else pass_n++;
    total_n++; if (madr !== '0) $display("FAIL reset_madr: got %h want 0", madr); else pass_n++;
    total_n++; if ({idone, ddone} !== 2'b00) $display("FAIL reset_done: got %b want 00", {idone, ddone}); else pass_n++;
    total_n++; if ({irdata, drdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {irdata, drdata}); else pass_n++;
  endtask

  task automatic test_ifetch;
    mdone = 1'b1;
    ireq = 1'b1;
    iadr = 'h10;
    tick;
    total_n++; if ({men, mrwb, madr} !== {1'b1, 1'b1, 13'h10}) $display("FAIL ifetch_c1: got men=%b mrwb=%b madr=%h want 1 1 010", men, mrwb, madr); else pass_n++;
    tick;
    total_n++; if (idone !== 1'b1 || irdata !== 32'h8C020004) $display("FAIL ifetch_c2: got idone=%b irdata=%h want 1 8c020004", idone, irdata); else pass_n++;
    ireq = 1'b0;
    tick;
    total_n++; if ({idone, men, mbyteen} !== 6'b0) $display("FAIL ifetch_idle: got idone=%b men=%b mbyteen=%b want 0 0 0000", idone, men, mbyteen); else pass_n++;
    tick(2);
  endtask

  task automatic test_priority;
    ireq = 1'b1; iadr = 'h10;
    dreq = 1'b1; drwb = 1'b1; dadr = 'h20;
    tick;
    total_n++; if ({men, mrwb, madr} !== {1'b1, 1'b1, 13'h20}) $display("FAIL prio_dfirst: got men=%b mrwb=%b madr=%h want 1 1 020", men, mrwb, madr); else pass_n++;
    tick;
    total_n++; if ({ddone, idone} !== 2'b10 || drdata !== 32'h11223344) $display("FAIL prio_ddone: got ddone=%b idone=%b drdata=%h want 1 0 11223344", ddone, idone, drdata); else pass_n++;
    dreq = 1'b0;
    tick(2);
    total_n++; if (idone !== 1'b0 || madr !== 13'h10 || men !== 1'b1) $display("FAIL prio_ird: got idone=%b men=%b madr=%h want 0 1 010", idone, men, madr); else pass_n++;
    tick;
    total_n++; if (idone !== 1'b1 || irdata !== 32'h8C020004) $display("FAIL prio_idone3: got idone=%b irdata=%h want 1 8c020004", idone, irdata); else pass_n++;
    ireq = 1'b0;
    tick(2);
  endtask

  task automatic test_wait;
    mdone = 1'b0;
    dreq = 1'b1; drwb = 1'b1; dadr = 'h21;
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      total_n++;
      if ({men, mrwb, madr, ddone} !== {1'b1, 1'b1, 13'h21, 1'b0})
        $display("FAIL wait_hold%0d: got men=%b mrwb=%b madr=%h ddone=%b want 1 1 021 0", i, men, mrwb, madr, ddone);
      else pass_n++;
    end
    mdone = 1'b1;
    tick;
    total_n++; if (ddone !== 1'b1 || drdata !== 32'h55AA00FF) $display("FAIL wait_done: got ddone=%b drdata=%h want 1 55aa00ff", ddone, drdata); else pass_n++;
    dreq = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    mdone = 1'b0;
    dreq = 1'b1; drwb = 1'b1; dadr = 'h20;
    tick;
    total_n++; if (men !== 1'b1) $display("FAIL rmid_drd: got men=%b want 1", men); else pass_n++;
    reset = 1'b1;
    dreq = 1'b0;
    tick;
    total_n++; if ({men, mrwb, ddone} !== 3'b010) $display("FAIL rmid_abort: got men=%b mrwb=%b ddone=%b want 0 1 0", men, mrwb, ddone); else pass_n++;
    reset = 1'b0;
    mdone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total_n++; if (ddone !== 1'b0) $display("FAIL rmid_noddone%0d: got %b want 0", i, ddone); else pass_n++;
    end
`ifdef EXTMEM_CTRL_WBUF_EN
    mdone = 1'b0;
    dreq = 1'b1; drwb = 1'b0; dadr = 'h44; dwdata = 32'h01020304; dbyteen = 4'hF;
    tick;
    total_n++; if (ddone !== 1'b1) $display("FAIL rmid_push: got ddone=%b want 1", ddone); else pass_n++;
    dreq = 1'b0;
    tick(3);
    total_n++; if ({men, mrwb} !== 2'b10) $display("FAIL rmid_wrstuck: got men=%b mrwb=%b want 1 0", men, mrwb); else pass_n++;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    mdone = 1'b1;
    dreq = 1'b1; drwb = 1'b1; dadr = 'h44;
    tick;
    total_n++; if ({men, mrwb, madr} !== {1'b1, 1'b1, 13'h44}) $display("FAIL rmid_fifo_empty: got men=%b mrwb=%b madr=%h want 1 1 044", men, mrwb, madr); else pass_n++;
    tick;
    total_n++; if (ddone !== 1'b1 || drdata !== pat('h44)) $display("FAIL rmid_read: got ddone=%b drdata=%h want 1 %h", ddone, drdata, pat('h44)); else pass_n++;
    dreq = 1'b0;
    tick(2);
`endif
  endtask

`ifdef EXTMEM_CTRL_WBUF_EN
  task automatic test_write_merge;
    int k;
    mdone = 1'b1;
    dreq = 1'b1; drwb = 1'b0; dadr = 'h40; dwdata = 32'hDEADBEEF; dbyteen = 4'b0011;
    tick;
    total_n++; if (ddone !== 1'b1) $display("FAIL merge_posted: got ddone=%b want 1", ddone); else pass_n++;
    drwb = 1'b1;
    tick(2);
    total_n++;
    if ({men, mrwb, madr, mbyteen, mdata} !== {1'b1, 1'b0, 13'h40, 4'b0011, 32'hDEADBEEF})
      $display("FAIL merge_drain: got men=%b mrwb=%b madr=%h be=%b mdata=%h want 1 0 040 0011 deadbeef", men, mrwb, madr, mbyteen, mdata);
    else pass_n++;
    k = 0;
    tick;
    while (!ddone && k < 20) begin tick; k++; end
    total_n++; if (ddone !== 1'b1 || drdata !== 32'hCAFEBEEF) $display("FAIL merge_read: got ddone=%b drdata=%h want 1 cafebeef", ddone, drdata); else pass_n++;
    dreq = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back;
    mdone = 1'b0;
    dreq = 1'b1; drwb = 1'b0; dadr = 'h50; dwdata = 32'h0000A001; dbyteen = 4'hF;
    tick;
    total_n++; if (ddone !== 1'b1) $display("FAIL b2b_w1: got ddone=%b want 1", ddone); else pass_n++;
    dadr = 'h51; dwdata = 32'h0000A002;
    tick(2);
    total_n++; if (ddone !== 1'b1) $display("FAIL b2b_w2: got ddone=%b want 1", ddone); else pass_n++;
    dadr = 'h52; dwdata = 32'h0000A003;
    for (int i = 0; i < 4; i++) begin
      tick;
      total_n++; if (ddone !== 1'b0) $display("FAIL b2b_w3_stall%0d: got ddone=%b want 0", i, ddone); else pass_n++;
    end
    mdone = 1'b1;
    tick;
    total_n++; if (ddone !== 1'b1) $display("FAIL b2b_w3_done: got ddone=%b want 1", ddone); else pass_n++;
    dreq = 1'b0;
    tick(12);
    total_n++;
    if ({mem['h50], mem['h51], mem['h52]} !== {32'h0000A001, 32'h0000A002, 32'h0000A003})
      $display("FAIL b2b_mem: got %h %h %h want 0000a001 0000a002 0000a003", mem['h50], mem['h51], mem['h52]);
    else pass_n++;
  endtask
`else
  task automatic test_write_direct;
    mdone = 1'b1;
    dreq = 1'b1; drwb = 1'b0; dadr = 'h60; dwdata = 32'h12345678; dbyteen = 4'b1100;
    tick;
    total_n++;
    if ({men, mrwb, madr, mbyteen, mdata} !== {1'b1, 1'b0, 13'h60, 4'b1100, 32'h12345678})
      $display("FAIL wdir_wr: got men=%b mrwb=%b madr=%h be=%b mdata=%h want 1 0 060 1100 12345678", men, mrwb, madr, mbyteen, mdata);
    else pass_n++;
    tick;
    total_n++; if (ddone !== 1'b1 || mem['h60] !== 32'h1234AAAA) $display("FAIL wdir_done: got ddone=%b mem=%h want 1 1234aaaa", ddone, mem['h60]); else pass_n++;
    drwb = 1'b1;
    tick(3);
    total_n++; if (ddone !== 1'b1 || drdata !== 32'h1234AAAA) $display("FAIL wdir_read: got ddone=%b drdata=%h want 1 1234aaaa", ddone, drdata); else pass_n++;
    dreq = 1'b0;
    tick(2);
  endtask
`endif

  initial begin
    test_reset;
    test_ifetch;
    test_priority;
    test_wait;
`ifdef EXTMEM_CTRL_WBUF_EN
    test_write_merge;
    test_back_to_back;
`else
    test_write_direct;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
